exe_wb_stage: RTL
=================

// Module: exe_wb_stage
// PURPOSE
//  EXE->WB boundary of the 4-stage pipeline: accepts ALU results and destination
//  register from EXE, buffers them in a 2-entry skid queue, and drives the register-file
//  write port under a valid/ready handshake. Returns in-flight results to ID as bypass
//  data (optional), closing the ID->EXE->WB->ID loop.
// PARAMETERS
//  DSIZE   32  data width (ALU result / regfile word)
//  ASIZE   5   register address width
//  CSIZE   16  retired-instruction counter width
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  exe_valid    in   1      EXE presents a result this cycle
//  exe_ready    out  1      stage can accept (registered, = !full)
//  exe_wen      in   1      instruction writes a register
//  exe_waddr    in   ASIZE  destination register
//  exe_wdata    in   DSIZE  ALU result
//  wb_valid     out  1      head entry valid
//  wb_ready     in   1      regfile write port accepts head
//  wb_wen       out  1      head valid & head wen & waddr!=0
//  wb_waddr     out  ASIZE  head destination
//  wb_wdata     out  DSIZE  head data
//  id_rs_addr   in   ASIZE  ID operand 1 address
//  id_rt_addr   in   ASIZE  ID operand 2 address
//  fwd_rs_hit   out  1      bypass available for rs
//  fwd_rs_data  out  DSIZE  bypass data for rs
//  fwd_rt_hit   out  1      bypass available for rt
//  fwd_rt_data  out  DSIZE  bypass data for rt
//  retired_cnt  out  CSIZE  count of entries retired via WB handshake
// BEHAVIOUR
//  - Reset (rst_n=0, async): queue EMPTY, exe_ready=1, wb_valid=0, wb_wen=0,
//    wb_waddr=0, wb_wdata=0, fwd_*=0, retired_cnt=0. Reset mid-transfer drops all entries.
//  - Accept: exe_valid & exe_ready at edge -> entry {wen,waddr,wdata} enqueued at tail.
//  - Retire: wb_valid & wb_ready at edge -> head dequeued, retired_cnt+1 (wraps 2^CSIZE-1->0).
//    Entries with wen=0 or waddr=0 still occupy a slot and retire; wb_wen=0 for them.
//  - Queue FSM: EMPTY/ONE/TWO.
//    EMPTY: accept->ONE. ONE: accept only->TWO; retire only->EMPTY; both->ONE (new
//    entry becomes head same edge). TWO: exe_ready=0, retire->ONE (tail promotes to head).
//  - Latency: accepted entry visible on wb_* the cycle after acceptance when queue was
//    EMPTY or head retired that edge; exe_ready deasserts the cycle after reaching TWO.
//  - exe_ready registered (no comb path from wb_ready); wb_* driven from head regs only.
//  - exe_valid while exe_ready=0: ignored, EXE must hold (no loss, no duplication).
//  - wb_* held stable while wb_valid & !wb_ready.
//  - Write ordering preserved: head always oldest; regfile writes strictly in program order.
// CONFIGURATION
//  FORWARD_EN defined: combinational compare of id_rs_addr/id_rt_addr vs all valid
//   entries with wen=1 and waddr!=0; tail (youngest) beats head; hit asserts, data = match.
//   Address 0 never hits. Same-cycle accepted entry not visible until next cycle.
//  FORWARD_EN undefined: compare logic absent; fwd_*_hit=0, fwd_*_data=0 always.
// TESTING
//  1 reset: rst_n low mid-cycle with queue TWO -> all outputs 0, exe_ready=1 immediately.
//  2 stream: wb_ready=1, 8 back-to-back results r1..r8=0x11..0x88 -> each on wb_* 1 cycle
//    later, exe_ready stays 1, retired_cnt=8.
//  3 backpressure: wb_ready=0, push 0xA,0xB,0xC -> exe_ready=0 after 2; 0xC held by EXE;
//    release wb_ready -> writes 0xA,0xB,0xC in order, none lost/duplicated.
//  4 simultaneous: queue ONE, accept+retire same edge -> stays ONE, new entry at head.
//  5 r0/no-wen: waddr=0 data 0xDEAD, and wen=0 entry -> wb_wen=0, both retire, cnt+2.
//  6 FORWARD_EN: head r3=0x5, tail r3=0x9, id_rs=3 -> hit=1, data=0x9; id_rt=0 -> hit=0;
//    without macro -> all fwd outputs 0; retired_cnt wrap at CSIZE=4 after 16 retires -> 0.

Source files
------------

// File: rtl/exe_wb_if.sv
// EXE->WB handshake bundle: the EXE result push side and the register-file write side.
// The stage uses the slave modport; the producer/consumer environment uses master.
interface exe_wb_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) ();
  logic             exe_valid;
  logic             exe_ready;
  logic             exe_wen;
  logic [ASIZE-1:0] exe_waddr;
  logic [DSIZE-1:0] exe_wdata;
  logic             wb_valid;
  logic             wb_ready;
  logic             wb_wen;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_wdata;

  modport slave (
    input  exe_valid, exe_wen, exe_waddr, exe_wdata, wb_ready,
    output exe_ready, wb_valid, wb_wen, wb_waddr, wb_wdata
  );

  modport master (
    output exe_valid, exe_wen, exe_waddr, exe_wdata, wb_ready,
    input  exe_ready, wb_valid, wb_wen, wb_waddr, wb_wdata
  );
endinterface

// File: rtl/exe_wb_stage.sv
// EXE->WB pipeline boundary: 2-entry skid queue (head = oldest) feeding the
// register-file write port, with a retired-entry counter.
// Optional feature macro: FORWARD_EN -- when defined, in-flight entries are offered
// to ID as bypass data (tail beats head); when undefined all fwd_* outputs are 0.
module exe_wb_stage #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int CSIZE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  exe_wb_if.slave          bus,
  input  logic [ASIZE-1:0] id_rs_addr,
  input  logic [ASIZE-1:0] id_rt_addr,
  output logic             fwd_rs_hit,
  output logic [DSIZE-1:0] fwd_rs_data,
  output logic             fwd_rt_hit,
  output logic [DSIZE-1:0] fwd_rt_data,
  output logic [CSIZE-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  logic             exe_ready_r;
  logic             head_valid_r;
  logic             head_wen_r;   // effective write enable: wen & waddr != 0
  logic [ASIZE-1:0] head_waddr_r;
  logic [DSIZE-1:0] head_wdata_r;
  logic             tail_wen_r;
  logic [ASIZE-1:0] tail_waddr_r;
  logic [DSIZE-1:0] tail_wdata_r;
  logic [CSIZE-1:0] cnt_r;

  logic accept_s;
  logic retire_s;
  logic in_wen_s;

  assign accept_s = bus.exe_valid & exe_ready_r;
  assign retire_s = head_valid_r & bus.wb_ready;
  // Writes to r0 are folded into the stored enable so WB and bypass never see them.
  assign in_wen_s = bus.exe_wen & (bus.exe_waddr != {ASIZE{1'b0}});

  // Queue FSM: head/tail storage, occupancy and the registered ready (= next state not full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      exe_ready_r  <= 1'b1;
      head_valid_r <= 1'b0;
      head_wen_r   <= 1'b0;
      head_waddr_r <= {ASIZE{1'b0}};
      head_wdata_r <= {DSIZE{1'b0}};
      tail_wen_r   <= 1'b0;
      tail_waddr_r <= {ASIZE{1'b0}};
      tail_wdata_r <= {DSIZE{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            head_valid_r <= 1'b1;
            head_wen_r   <= in_wen_s;
            head_waddr_r <= bus.exe_waddr;
            head_wdata_r <= bus.exe_wdata;
            state_r      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_s && retire_s) begin
            // Old head leaves, new entry becomes head on the same edge.
            head_wen_r   <= in_wen_s;
            head_waddr_r <= bus.exe_waddr;
            head_wdata_r <= bus.exe_wdata;
          end else if (accept_s) begin
            tail_wen_r   <= in_wen_s;
            tail_waddr_r <= bus.exe_waddr;
            tail_wdata_r <= bus.exe_wdata;
            exe_ready_r  <= 1'b0;
            state_r      <= ST_TWO;
          end else if (retire_s) begin
            head_valid_r <= 1'b0;
            head_wen_r   <= 1'b0;
            head_waddr_r <= {ASIZE{1'b0}};
            head_wdata_r <= {DSIZE{1'b0}};
            state_r      <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (retire_s) begin
            // Tail promotes to head; a slot frees, so ready returns next cycle.
            head_wen_r   <= tail_wen_r;
            head_waddr_r <= tail_waddr_r;
            head_wdata_r <= tail_wdata_r;
            tail_wen_r   <= 1'b0;
            tail_waddr_r <= {ASIZE{1'b0}};
            tail_wdata_r <= {DSIZE{1'b0}};
            exe_ready_r  <= 1'b1;
            state_r      <= ST_ONE;
          end
        end
        default: begin
          state_r      <= ST_EMPTY;
          exe_ready_r  <= 1'b1;
          head_valid_r <= 1'b0;
          head_wen_r   <= 1'b0;
          tail_wen_r   <= 1'b0;
        end
      endcase
    end
  end

  // Retired-entry counter, wraps naturally at 2^CSIZE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CSIZE{1'b0}};
    end else if (retire_s) begin
      cnt_r <= cnt_r + {{(CSIZE-1){1'b0}}, 1'b1};
    end
  end

  assign bus.exe_ready = exe_ready_r;
  assign bus.wb_valid  = head_valid_r;
  assign bus.wb_wen    = head_wen_r;
  assign bus.wb_waddr  = head_waddr_r;
  assign bus.wb_wdata  = head_wdata_r;
  assign retired_cnt   = cnt_r;

`ifdef FORWARD_EN
  logic tail_valid_s;
  assign tail_valid_s = (state_r == ST_TWO);

  // Bypass lookup: {hit, data}; youngest matching entry wins.
  function automatic logic [DSIZE:0] fwd_lookup(input logic [ASIZE-1:0] addr);
    logic [DSIZE:0] res;
    if (tail_valid_s && tail_wen_r && (tail_waddr_r == addr)) begin
      res = {1'b1, tail_wdata_r};
    end else if (head_valid_r && head_wen_r && (head_waddr_r == addr)) begin
      res = {1'b1, head_wdata_r};
    end else begin
      res = {1'b0, {DSIZE{1'b0}}};
    end
    return res;
  endfunction

  // Combinational bypass compare for both ID operands.
  always_comb begin
    {fwd_rs_hit, fwd_rs_data} = fwd_lookup(id_rs_addr);
    {fwd_rt_hit, fwd_rt_data} = fwd_lookup(id_rt_addr);
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{id_rs_addr, id_rt_addr};
  assign fwd_rs_hit   = 1'b0;
  assign fwd_rs_data  = {DSIZE{1'b0}};
  assign fwd_rt_hit   = 1'b0;
  assign fwd_rt_data  = {DSIZE{1'b0}};
`endif

endmodule
